// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_WIDTH register file with one write port and two
// registered read ports (1-cycle latency). A write to the address being read
// in the same cycle is forwarded to the read result.
// Optional build macro: REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_2r1w #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_1,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  rd_valid_1,
  input  logic                  rd_en_2,
  input  logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  rd_valid_2
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Storage is cleared by reset, so it is built from flops rather than RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // A write is only effective when it does not target a hardwired zero entry;
  // this same qualifier gates bypass, so address 0 never forwards.
  logic w_wr_ok;
  assign w_wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  // Array update: reset clears every entry, otherwise the write port lands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Per-port request views so both read ports share one generated body.
  logic                  w_rd_en   [2];
  logic [ADDR_WIDTH-1:0] w_rd_addr [2];

  assign w_rd_en[0]   = rd_en_1;
  assign w_rd_en[1]   = rd_en_2;
  assign w_rd_addr[0] = rd_addr_1;
  assign w_rd_addr[1] = rd_addr_2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_WIDTH-1:0] w_rd_sel;
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      // Select array contents, overridden by a same-cycle write, then by zero entry.
      always_comb begin
        w_rd_sel = r_mem[w_rd_addr[gi]];
        if (w_wr_ok && (wr_addr == w_rd_addr[gi])) begin
          w_rd_sel = wr_data;
        end
        if (ZERO_REG && (w_rd_addr[gi] == '0)) begin
          w_rd_sel = '0;
        end
      end

      // Output register: disabled ports present zero so no stale data leaks.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_en[gi];
          r_rd_data  <= w_rd_en[gi] ? w_rd_sel : '0;
        end
      end
    end
  endgenerate

  assign rd_data_1  = g_port[0].r_rd_data;
  assign rd_valid_1 = g_port[0].r_rd_valid;
  assign rd_data_2  = g_port[1].r_rd_data;
  assign rd_valid_2 = g_port[1].r_rd_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: an 8x16 instance driven from a vector
// table plus hand sequences for reset, and a 32x32 instance for wide data.
// Expected values for address 0 follow REGFILE_ZERO_REG_EN.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit x 16 instance
  logic       wr_en, rd_en_1, rd_en_2;
  logic [3:0] wr_addr, rd_addr_1, rd_addr_2;
  logic [7:0] wr_data, rd_data_1, rd_data_2;
  logic       rd_valid_1, rd_valid_2;

  regfile_2r1w #(.DATA_WIDTH(8), .DEPTH(16)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_valid_1(rd_valid_1),
    .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_valid_2(rd_valid_2)
  );

  // 32-bit x 32 instance
  logic        w_wr_en, w_rd_en_1, w_rd_en_2;
  logic [4:0]  w_wr_addr, w_rd_addr_1, w_rd_addr_2;
  logic [31:0] w_wr_data, w_rd_data_1, w_rd_data_2;
  logic        w_rd_valid_1, w_rd_valid_2;

  regfile_2r1w #(.DATA_WIDTH(32), .DEPTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_en_1(w_rd_en_1), .rd_addr_1(w_rd_addr_1), .rd_data_1(w_rd_data_1), .rd_valid_1(w_rd_valid_1),
    .rd_en_2(w_rd_en_2), .rd_addr_2(w_rd_addr_2), .rd_data_2(w_rd_data_2), .rd_valid_2(w_rd_valid_2)
  );

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [7:0]  Z8  = 8'h00;
  localparam logic [31:0] Z32 = 32'h0000_0000;
`else
  localparam logic [7:0]  Z8  = 8'h99;
  localparam logic [31:0] Z32 = 32'h0000_0001;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_1;
    logic [3:0] rd_addr_1;
    logic       rd_en_2;
    logic [3:0] rd_addr_2;
    logic       exp_v1;
    logic [7:0] exp_d1;
    logic       exp_v2;
    logic [7:0] exp_d2;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic r1, input logic [3:0] a1,
                        input logic r2, input logic [3:0] a2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_1 = r1; rd_addr_1 = a1; rd_en_2 = r2; rd_addr_2 = a2;
  endtask

  task automatic drive32(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
    w_wr_en = we; w_wr_addr = wa; w_wr_data = wd;
    w_rd_en_1 = r1; w_rd_addr_1 = a1; w_rd_en_2 = r2; w_rd_addr_2 = a2;
  endtask

  initial begin
    //          we   wa     wd     r1   a1     r2   a2     v1   d1     v2   d2
    vecs[0]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 8'h00, 1'b1, 8'h00}; // post-reset read
    vecs[1]  = '{1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 4'd7, 8'h11, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 8'h3C, 1'b1, 8'h3C}; // bypass both
    vecs[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 8'h3C, 1'b1, 8'h3C};
    vecs[6]  = '{1'b1, 4'd9, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b0, 4'd9, 1'b1, 8'hFF, 1'b0, 8'h00}; // disabled port
    vecs[8]  = '{1'b1, 4'd4, 8'h5A, 1'b1, 4'd4, 1'b1, 4'd3, 1'b1, 8'h5A, 1'b1, 8'hA5};
    vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b0, 4'd4, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 4'd0, 8'h99, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, Z8,    1'b1, Z8   }; // addr 0 bypass
    vecs[11] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, Z8,    1'b1, Z8   };
    vecs[12] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 4'd7, 1'b1, 8'hA5, 1'b1, 8'h3C};
    vecs[13] = '{1'b1, 4'd3, 8'hC3, 1'b1, 4'd7, 1'b1, 4'd3, 1'b1, 8'h3C, 1'b1, 8'hC3};

    drive8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    drive32(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset held low for two cycles, with a read pending to prove override.
    reset_n = 1'b0;
    rd_en_1 = 1'b1;
    tick();
    tick();
    check("reset_v1", 32'(rd_valid_1), 32'd0);
    check("reset_v2", 32'(rd_valid_2), 32'd0);
    check("reset_d1", 32'(rd_data_1), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive8(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
             vecs[i].rd_en_1, vecs[i].rd_addr_1, vecs[i].rd_en_2, vecs[i].rd_addr_2);
      tick();
      check($sformatf("v%0d_valid1", i), 32'(rd_valid_1), 32'(vecs[i].exp_v1));
      check($sformatf("v%0d_data1",  i), 32'(rd_data_1),  32'(vecs[i].exp_d1));
      check($sformatf("v%0d_valid2", i), 32'(rd_valid_2), 32'(vecs[i].exp_v2));
      check($sformatf("v%0d_data2",  i), 32'(rd_data_2),  32'(vecs[i].exp_d2));
      $display("vec %0d: v1=%0b d1=%02h v2=%0b d2=%02h", i, rd_valid_1, rd_data_1, rd_valid_2, rd_data_2);
    end

    // Wide instance: fill top and bottom entries, read both in one cycle.
    drive8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    drive32(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive32(1'b1, 5'd0, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive32(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd0);
    tick();
    check("w32_data1", w_rd_data_1, 32'hDEAD_BEEF);
    check("w32_data2", w_rd_data_2, Z32);
    check("w32_valid2", 32'(w_rd_valid_2), 32'd1);
    $display("w32 read: d1=%08h d2=%08h", w_rd_data_1, w_rd_data_2);
    drive32(1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd31, 1'b0, 5'd31);
    tick();
    check("w32_bypass_d1", w_rd_data_1, 32'hCAFE_F00D);
    check("w32_dis_d2", w_rd_data_2, 32'h0);
    $display("w32 bypass: d1=%08h d2=%08h", w_rd_data_1, w_rd_data_2);
    drive32(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset mid-stream: write and reads in the reset cycle must not take effect.
    reset_n = 1'b0;
    drive8(1'b1, 4'd2, 8'h77, 1'b1, 4'd2, 1'b1, 4'd2);
    tick();
    check("mid_rst_v1", 32'(rd_valid_1), 32'd0);
    check("mid_rst_v2", 32'(rd_valid_2), 32'd0);
    check("mid_rst_d1", 32'(rd_data_1), 32'd0);
    $display("mid reset: v1=%0b d1=%02h", rd_valid_1, rd_data_1);
    reset_n = 1'b1;
    drive8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive8(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd3);
    tick();
    check("post_rst_v1", 32'(rd_valid_1), 32'd1);
    check("post_rst_d1", 32'(rd_data_1), 32'd0);
    check("post_rst_d2", 32'(rd_data_2), 32'd0);
    $display("post reset read: d1=%02h d2=%02h", rd_data_1, rd_data_2);
    drive8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    check("idle_v1", 32'(rd_valid_1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
